core_launcher: RTL and testbench
================================

# core_launcher

Sequencer directly upstream of the processor top level. It streams 9-bit machine code into the instruction memory write port and holds the core in reset while loading. On `start` it releases the core, pulses its `req` input, waits for its `done`, and reports the run's cycle count. It also guards against program overflow and runaway execution with sticky error reporting.

## Interface
- `D`, 12: PC / instruction-memory address width.
- `W`, 9: machine-code word width.
- `CW`, 16: cycle-counter width.
- `TIMEOUT`, 10000: maximum RUN cycles before error; must be ≤ 2**CW-1.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `ld_valid`  in  1  loader word valid.
- `ld_data`  in  W  machine-code word.
- `ld_last`  in  1  marks final word of the program.
- `ld_ready`  out  1  launcher accepts words.
- `start`  in  1  run request (level sampled, acted on in READY/DONE).
- `im_wr_en`  out  1  instruction-memory write strobe.
- `im_addr`  out  D  instruction-memory write address.
- `im_dat`  out  W  instruction-memory write data.
- `core_reset`  out  1  drives core `reset`.
- `core_req`  out  1  drives core `req`.
- `core_done`  in  1  core `done`.
- `busy`  out  1  high in LOAD, BOOT, RUN.
- `finished`  out  1  high in DONE.
- `err`  out  1  sticky error (overflow or timeout).
- `prog_len`  out  D+1  number of words in the last loaded program.
- `cycles`  out  CW  RUN-cycle count of the current or last run.

## Operation
- States: IDLE, LOAD, READY, BOOT, RUN, DONE, ERR.
- Reset values: state IDLE, core_reset=1, core_req=0, im_wr_en=0, im_addr=0, im_dat=0, prog_len=0, cycles=0, finished=0, err=0, busy=0.
- `ld_ready`=1 in IDLE, LOAD, DONE; 0 elsewhere. A word is accepted on `ld_valid && ld_ready`.
- IDLE/DONE + accept: wr_ptr←0, the word is written at address 0, go to LOAD (go to READY if ld_last). `start` is ignored in IDLE.
- LOAD: each accepted word is written at wr_ptr, then wr_ptr++.
  - Accept with ld_last → READY; prog_len ← wr_ptr+1.
  - Accept at wr_ptr = 2**D-1 without ld_last → ERR.
- READY: `start` → BOOT.
- BOOT: exactly one cycle, core_reset=1, cycles←0, then → RUN.
- RUN: core_reset=0; core_req=1 on the first RUN cycle only.
  - Each RUN cycle with core_done=0: cycles++.
  - core_done=1 → DONE with cycles frozen. core_done wins over a simultaneous timeout.
  - cycles = TIMEOUT-1 with core_done=0 → ERR.
- DONE: core_reset=1 so the PC is parked while data memory is retained. finished=1.
  - `start` → BOOT, re-running the same program.
  - Accept → LOAD a new program. If `start` and accept occur in the same cycle, accept wins.
- ERR: core_reset=1, err=1, ld_ready=0. Only `reset` exits ERR.
- core_reset=1 in every state except RUN.
- `reset` mid-load or mid-run aborts immediately to IDLE. Instruction memory contents are not cleared.

## Timing
- Word accepted in cycle t → im_wr_en=1 with im_addr/im_dat valid in cycle t+1, for one cycle per word. Back-to-back accepts give back-to-back writes.
- Last word accepted at t → READY at t+1. The final write also lands at t+1, so `start` at t+1 is legal.
- start sampled at t → BOOT at t+1, RUN at t+2.
  - At t+2: core_reset falls and core_req is high for exactly cycle t+2.
- core_done first high at cycle t+2+k → DONE at t+3+k, with cycles=k.
- Timeout: ERR entered TIMEOUT cycles after RUN entry.
- All outputs are registered. No combinational path from `core_done` or `ld_valid` to any output.

## Structure
- Package `launcher_pkg`: state enum typedef `launch_state_t`, and the default `TIMEOUT` constant.
- One sub-module, `run_timer`: CW-bit counter with clear, enable and terminal-count compare against TIMEOUT-1. Everything else is in `core_launcher`.

## Test plan
- Load 5 words 0x1C0..0x1C4 with ld_last on the 5th, no gaps → writes to addresses 0..4 on consecutive cycles, prog_len=5, state READY, ld_ready=0.
- Load with ld_valid toggling every other cycle → only accepted words written, addresses contiguous, no duplicate writes.
- After load, start; model core asserts core_done 40 cycles after core_reset falls → core_req single-cycle pulse, finished=1, cycles=40, core_reset=1 again.
- TIMEOUT=100 and core_done never asserted → err=1 exactly 100 cycles after RUN entry, ld_ready=0; start ignored until reset.
- D=3: stream 9 words without ld_last → 8 writes to addresses 0..7, then ERR.
- From DONE: assert start and ld_valid together → new load wins (write at address 0); later assert reset mid-RUN → IDLE next cycle, core_reset=1, cycles=0.

Source files
------------

// File: rtl/launcher_pkg.sv
// Shared types and defaults for the core launcher sequencer.
package launcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_BOOT,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } launch_state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 10000;

endpackage

// File: rtl/core_launcher_run_timer.sv
// RUN-phase cycle counter with clear/enable and a terminal count at TIMEOUT-1.
module run_timer
  import launcher_pkg::*;
#(
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_launcher.sv
// Loads machine code into instruction memory, then boots the core and times
// its run, with sticky overflow / timeout error reporting.
module core_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned D       = 12,
  parameter int unsigned W       = 9,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [W-1:0]  ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          start,
  output logic          im_wr_en,
  output logic [D-1:0]  im_addr,
  output logic [W-1:0]  im_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [D:0]    prog_len,
  output logic [CW-1:0] cycles
);

  launch_state_t state, nxt;
  logic [D-1:0]  wr_ptr;
  logic [D-1:0]  wr_addr;
  logic          accept;
  logic          run_tc;

  assign accept  = ld_valid && ld_ready;
  // A fresh load (from IDLE or DONE) always restarts at address 0.
  assign wr_addr = (state == ST_LOAD) ? wr_ptr : '0;

  run_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_BOOT),
    .en    ((state == ST_RUN) && !core_done),
    .count (cycles),
    .tc    (run_tc)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) nxt = ld_last ? ST_READY : ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (ld_last)           nxt = ST_READY;
          else if (wr_ptr == '1) nxt = ST_ERR;
        end
      end
      ST_READY: if (start) nxt = ST_BOOT;
      ST_BOOT:  nxt = ST_RUN;
      ST_RUN: begin
        if (core_done)   nxt = ST_DONE;
        else if (run_tc) nxt = ST_ERR;
      end
      ST_DONE: begin
        if (accept)     nxt = ld_last ? ST_READY : ST_LOAD;
        else if (start) nxt = ST_BOOT;
      end
      ST_ERR:   nxt = ST_ERR;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      im_wr_en   <= 1'b0;
      im_addr    <= '0;
      im_dat     <= '0;
      prog_len   <= '0;
      ld_ready   <= 1'b1;
      busy       <= 1'b0;
      finished   <= 1'b0;
      err        <= 1'b0;
      core_reset <= 1'b1;
      core_req   <= 1'b0;
    end else begin
      state    <= nxt;
      im_wr_en <= accept;
      if (accept) begin
        im_addr <= wr_addr;
        im_dat  <= ld_data;
        wr_ptr  <= wr_addr + D'(1);
        if (ld_last) prog_len <= {1'b0, wr_addr} + (D+1)'(1);
      end
      ld_ready   <= (nxt == ST_IDLE) || (nxt == ST_LOAD) || (nxt == ST_DONE);
      busy       <= (nxt == ST_LOAD) || (nxt == ST_BOOT) || (nxt == ST_RUN);
      finished   <= (nxt == ST_DONE);
      err        <= (nxt == ST_ERR);
      core_reset <= (nxt != ST_RUN);
      core_req   <= (state == ST_BOOT);
    end
  end

endmodule

// File: tb/tb_core_launcher.sv
// Self-checking bench for core_launcher: vector table, corner sequences and
// randomized load/run cycles against a behavioural write/length/cycle model.
module tb_core_launcher;

  localparam int unsigned D  = 3;
  localparam int unsigned W  = 9;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset, ld_valid, ld_last, ld_ready, start;
  logic [W-1:0]  ld_data;
  logic          im_wr_en, core_reset, core_req, core_done;
  logic [D-1:0]  im_addr;
  logic [W-1:0]  im_dat;
  logic          busy, finished, err;
  logic [D:0]    prog_len;
  logic [CW-1:0] cycles;

  core_launcher #(.D(D), .W(W), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .start(start),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_dat(im_dat),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .busy(busy), .finished(finished), .err(err),
    .prog_len(prog_len), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (im_wr_en) got_q.push_back({16'(im_addr), 16'(im_dat)});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, ".nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, ".waddr"}, {16'h0, got_q[i][31:16]}, {16'h0, exp_q[i][31:16]});
      chk({tag, ".wdata"}, {16'h0, got_q[i][15:0]},  {16'h0, exp_q[i][15:0]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // mode 0: back-to-back, 1: one idle cycle before each word, 2: 0..3 random idles
  task automatic load(input int unsigned n, input int unsigned mode, input bit with_last,
                      input int unsigned base);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned idles;
      idles = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 3);
      for (int unsigned j = 0; j < idles; j++) begin
        ld_valid = 1'b0;
        tick();
      end
      ld_valid = 1'b1;
      ld_data  = W'($urandom_range(0, 511));
      ld_last  = with_last && (i == n - 1);
      if (base + i < (1 << D)) exp_q.push_back({16'(base + i), 16'(ld_data)});
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    chk("boot.busy", busy, 1'b1);
    chk("boot.core_reset", core_reset, 1'b1);
    chk("boot.core_req", core_req, 1'b0);
    start = 1'b0;
    tick();
    chk("run.core_req_first", core_req, 1'b1);
    chk("run.core_reset", core_reset, 1'b0);
  endtask

  task automatic run_core(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      core_done = 1'b0;
      tick();
      if (i == 0) chk("run.core_req_pulse", core_req, 1'b0);
    end
    chk("run.busy", busy, 1'b1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("done.finished", finished, 1'b1);
    chk("done.cycles", cycles, k);
    chk("done.core_reset", core_reset, 1'b1);
    chk("done.busy", busy, 1'b0);
    chk("done.err", err, 1'b0);
    chk("done.ld_ready", ld_ready, 1'b1);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         last;
    logic         st;
    logic [6:0]   exp;   // {ld_ready, busy, finished, err, core_reset, core_req, im_wr_en}
    logic [D-1:0] ea;
    logic [W-1:0] ed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    start = 1'b0; core_done = 1'b0;
    tbl[0] = '{1'b1, 9'h1C0, 1'b0, 1'b0, 7'b1100101, 3'd0, 9'h1C0};
    tbl[1] = '{1'b1, 9'h1C1, 1'b0, 1'b0, 7'b1100101, 3'd1, 9'h1C1};
    tbl[2] = '{1'b1, 9'h1C2, 1'b0, 1'b0, 7'b1100101, 3'd2, 9'h1C2};
    tbl[3] = '{1'b1, 9'h1C3, 1'b0, 1'b0, 7'b1100101, 3'd3, 9'h1C3};
    tbl[4] = '{1'b1, 9'h1C4, 1'b1, 1'b0, 7'b0000101, 3'd4, 9'h1C4};
    tbl[5] = '{1'b0, 9'h000, 1'b0, 1'b0, 7'b0000100, 3'd0, 9'h000};
    tbl[6] = '{1'b0, 9'h000, 1'b0, 1'b1, 7'b0100100, 3'd0, 9'h000};
    tbl[7] = '{1'b0, 9'h000, 1'b0, 1'b0, 7'b0100010, 3'd0, 9'h000};

    tick();
    tick();
    chk("rst.flags", {ld_ready, busy, finished, err, core_reset, core_req, im_wr_en}, 7'b1000100);
    chk("rst.im_addr", im_addr, 0);
    chk("rst.im_dat", im_dat, 0);
    chk("rst.prog_len", prog_len, 0);
    chk("rst.cycles", cycles, 0);
    reset = 1'b0;
    tick();
    chk("idle.flags", {ld_ready, busy, finished, err, core_reset, core_req, im_wr_en}, 7'b1000100);

    // Table: 5-word gapless load, start, boot, first RUN cycle
    for (int i = 0; i < 8; i++) begin
      ld_valid = tbl[i].v;
      ld_data  = tbl[i].d;
      ld_last  = tbl[i].last;
      start    = tbl[i].st;
      tick();
      chk($sformatf("tbl%0d.flags", i),
          {ld_ready, busy, finished, err, core_reset, core_req, im_wr_en}, tbl[i].exp);
      if (tbl[i].exp[0]) begin
        chk($sformatf("tbl%0d.im_addr", i), im_addr, tbl[i].ea);
        chk($sformatf("tbl%0d.im_dat", i), im_dat, tbl[i].ed);
      end
      if (i == 4) chk("tbl.prog_len", prog_len, 5);
    end
    for (int unsigned i = 0; i < 5; i++) exp_q.push_back({16'(i), 16'(9'h1C0 + i)});
    chk_writes("load5");
    run_core(40);
    tick();
    chk("done.cycles_frozen", cycles, 40);
    chk("done.finished_hold", finished, 1'b1);

    // DONE with start and accept together: the new load wins
    start = 1'b1; ld_valid = 1'b1; ld_data = 9'h155; ld_last = 1'b0;
    exp_q.push_back({16'd0, 16'h155});
    tick();
    start = 1'b0;
    chk("redo.busy", busy, 1'b1);
    chk("redo.finished", finished, 1'b0);
    chk("redo.we", im_wr_en, 1'b1);
    chk("redo.addr", im_addr, 0);
    chk("redo.core_reset", core_reset, 1'b1);
    load(5, 1, 1'b1, 1);
    chk("toggle.prog_len", prog_len, 6);
    chk_writes("toggle");
    go();
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    chk("midrun_rst.core_reset", core_reset, 1'b1);
    chk("midrun_rst.cycles", cycles, 0);
    chk("midrun_rst.busy", busy, 1'b0);
    chk("midrun_rst.ld_ready", ld_ready, 1'b1);
    reset = 1'b0;
    tick();

    // core_done on the terminal-count cycle still counts as completion
    load(3, 0, 1'b1, 0);
    chk_writes("tc_load");
    go();
    run_core(TO - 1);

    // Randomized programs and run lengths, reloaded from DONE each time
    for (int it = 0; it < 12; it++) begin
      int unsigned n, k, w;
      n = $urandom_range(1, 1 << D);
      k = $urandom_range(0, 98);
      w = $urandom_range(0, 3);
      load(n, 2, 1'b1, 0);
      chk("rnd.prog_len", prog_len, n);
      chk_writes("rnd");
      for (int unsigned j = 0; j < w; j++) begin
        tick();
        chk("rnd.ready_hold", {ld_ready, busy, finished}, 3'b000);
      end
      go();
      run_core(k);
    end

    // Timeout: err exactly TO cycles after RUN entry, then sticky
    load(2, 0, 1'b1, 0);
    chk_writes("to_load");
    go();
    for (int unsigned i = 0; i < TO - 1; i++) tick();
    chk("to.err_early", err, 1'b0);
    chk("to.busy_early", busy, 1'b1);
    tick();
    chk("to.err", err, 1'b1);
    chk("to.ld_ready", ld_ready, 1'b0);
    chk("to.core_reset", core_reset, 1'b1);
    chk("to.busy", busy, 1'b0);
    start = 1'b1; ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0; ld_valid = 1'b0;
    chk("to.sticky_err", err, 1'b1);
    chk("to.sticky_busy", busy, 1'b0);
    chk("to.no_writes", got_q.size(), 0);
    got_q.delete();

    // Overflow: 9 words without ld_last into an 8-entry memory
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    load(9, 0, 1'b0, 0);
    chk("ovf.err", err, 1'b1);
    chk("ovf.ld_ready", ld_ready, 1'b0);
    chk_writes("ovf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
